// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver and scancode decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } frame_state_e;

    // Keyboard status/protocol bytes that never represent a key.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_BAT_OK) || (b == PS2_ECHO) ||
               (b == PS2_ACK)  || (b == PS2_RESEND) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises ps2_clk/ps2_data, debounces the clock and emits a one-cycle
// strobe on each filtered falling edge.
module ps2_clk_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data
);

    localparam int unsigned CntW = $clog2(FILTER_LEN) + 1;

    logic [1:0]      clk_sync_q;
    logic [1:0]      data_sync_q;
    logic            filt_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
            fall        <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            fall        <= 1'b0;
            // cnt_q counts consecutive samples that disagree with the filtered level.
            if (clk_sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                filt_q <= clk_sync_q[1];
                cnt_q  <= '0;
                fall   <= filt_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign data = data_sync_q[1];

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard receiver: 11-bit frame FSM with timeout, followed by
// make/break/extended decode into a held scancode/keypressed level.
module ps2_keyboard_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       keypressed,
    output logic       extended,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic fall;
    logic sdata;

    frame_state_e    state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            parity;
    logic [TmoW-1:0] tmo_cnt;
    logic            brk_pending;
    logic            ext_pending;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .fall    (fall),
        .data    (sdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            bit_cnt     <= '0;
            shift       <= '0;
            parity      <= 1'b0;
            tmo_cnt     <= '0;
            brk_pending <= 1'b0;
            ext_pending <= 1'b0;
            scancode    <= '0;
            keypressed  <= 1'b0;
            extended    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (fall) begin
                tmo_cnt <= '0;
                unique case (state)
                    StIdle: begin
                        if (!sdata) begin
                            state   <= StData;
                            bit_cnt <= '0;
                        end
                    end
                    StData: begin
                        shift   <= {sdata, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= StParity;
                    end
                    StParity: begin
                        parity <= sdata;
                        state  <= StStop;
                    end
                    StStop: begin
                        state <= StIdle;
                        if (sdata && (^{shift, parity})) begin
                            rx_valid <= 1'b1;
                            rx_data  <= shift;
                            if (shift == PS2_EXT) begin
                                ext_pending <= 1'b1;
                            end else if (shift == PS2_BREAK) begin
                                brk_pending <= 1'b1;
                            end else begin
                                brk_pending <= 1'b0;
                                ext_pending <= 1'b0;
                                if (!is_ignored(shift)) begin
                                    if (brk_pending) begin
                                        // Only release the key currently reported as held.
                                        if (keypressed && shift == scancode &&
                                            ext_pending == extended) begin
                                            keypressed <= 1'b0;
                                        end
                                    end else begin
                                        scancode   <= shift;
                                        extended   <= ext_pending;
                                        keypressed <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end else if (state != StIdle) begin
                if (tmo_cnt == TmoW'(TIMEOUT_CYCLES - 1)) begin
                    state   <= StIdle;
                    tmo_cnt <= '0;
                    rx_err  <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Directed bench for ps2_keyboard_decoder: frames, decode rules, bad frames,
// timeout, glitch rejection and mid-frame reset.
module tb_ps2_keyboard_decoder;

    localparam int unsigned FILT = 4;
    localparam int unsigned TMO  = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode;
    logic       keypressed;
    logic       extended;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;

    int total = 0;
    int bad = 0;

    int         cyc = 0;
    int         n_valid = 0;
    int         n_err = 0;
    int         n_both = 0;
    int         n_kp_rise = 0;
    int         err_cyc = 0;
    int         last_low_cyc = 0;
    logic [7:0] last_data = 8'h00;
    logic       kp_prev = 1'b0;

    ps2_keyboard_decoder #(
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scancode  (scancode),
        .keypressed(keypressed),
        .extended  (extended),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        kp_prev <= keypressed;
        if (rx_valid) begin
            n_valid   <= n_valid + 1;
            last_data <= rx_data;
        end
        if (rx_err) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
        if (rx_valid && rx_err) n_both <= n_both + 1;
        if (keypressed && !kp_prev) n_kp_rise <= n_kp_rise + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (25) @(negedge clk);
        ps2_clk      = 1'b0;
        last_low_cyc = cyc;
        repeat (50) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (25) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(stop);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if ({scancode, keypressed, extended, rx_data, rx_valid, rx_err} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs: got=%h required=0",
                     {scancode, keypressed, extended, rx_data, rx_valid, rx_err});
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (n_valid + n_err !== 0) begin
            bad++;
            $display("FAIL reset_idle_pulses: got=%0d required=0", n_valid + n_err);
        end
    endtask

    task automatic test_make();
        int v0 = n_valid;
        int e0 = n_err;
        send_frame(8'h1C, 1'b0, 1'b1);
        total++;
        if (n_valid - v0 !== 1) begin
            bad++;
            $display("FAIL make_valid_count: got=%0d required=1", n_valid - v0);
        end
        total++;
        if (last_data !== 8'h1C) begin
            bad++;
            $display("FAIL make_rx_data: got=%h required=1c", last_data);
        end
        total++;
        if ({scancode, keypressed, extended} !== {8'h1C, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL make_decode: got=%h/%b/%b required=1c/1/0", scancode, keypressed, extended);
        end
        total++;
        if (n_err - e0 !== 0) begin
            bad++;
            $display("FAIL make_no_err: got=%0d required=0", n_err - e0);
        end
    endtask

    task automatic test_break_repeat();
        int v0;
        int r0;
        send_frame(8'hF0, 1'b0, 1'b1);
        total++;
        if ({scancode, keypressed} !== {8'h1C, 1'b1}) begin
            bad++;
            $display("FAIL break_prefix_hold: got=%h/%b required=1c/1", scancode, keypressed);
        end
        send_frame(8'h1C, 1'b0, 1'b1);
        total++;
        if ({scancode, keypressed, extended} !== {8'h1C, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL break_release: got=%h/%b/%b required=1c/0/0", scancode, keypressed, extended);
        end
        v0 = n_valid;
        r0 = n_kp_rise;
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        total++;
        if ({scancode, keypressed} !== {8'h1C, 1'b1}) begin
            bad++;
            $display("FAIL repeat_decode: got=%h/%b required=1c/1", scancode, keypressed);
        end
        total++;
        if (n_kp_rise - r0 !== 1) begin
            bad++;
            $display("FAIL repeat_single_update: got=%0d required=1", n_kp_rise - r0);
        end
        total++;
        if (n_valid - v0 !== 2) begin
            bad++;
            $display("FAIL repeat_valid_count: got=%0d required=2", n_valid - v0);
        end
    endtask

    task automatic test_extended();
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        total++;
        if ({scancode, keypressed, extended} !== {8'h75, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL ext_make: got=%h/%b/%b required=75/1/1", scancode, keypressed, extended);
        end
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        total++;
        if ({scancode, keypressed, extended} !== {8'h75, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL ext_mismatch_break: got=%h/%b/%b required=75/1/1",
                     scancode, keypressed, extended);
        end
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        total++;
        if ({scancode, keypressed, extended} !== {8'h75, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL ext_break: got=%h/%b/%b required=75/0/1", scancode, keypressed, extended);
        end
    endtask

    task automatic test_bad_frames();
        int v0 = n_valid;
        int e0 = n_err;
        send_frame(8'h75, 1'b1, 1'b1);
        total++;
        if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin
            bad++;
            $display("FAIL bad_parity_pulses: got err=%0d valid=%0d required err=1 valid=0",
                     n_err - e0, n_valid - v0);
        end
        total++;
        if ({scancode, keypressed, extended} !== {8'h75, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL bad_parity_hold: got=%h/%b/%b required=75/0/1", scancode, keypressed, extended);
        end
        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h5A, 1'b0, 1'b0);
        total++;
        if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin
            bad++;
            $display("FAIL bad_stop_pulses: got err=%0d valid=%0d required err=1 valid=0",
                     n_err - e0, n_valid - v0);
        end
        total++;
        if ({scancode, keypressed, extended} !== {8'h75, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL bad_stop_hold: got=%h/%b/%b required=75/0/1", scancode, keypressed, extended);
        end
        total++;
        if (n_both !== 0) begin
            bad++;
            $display("FAIL valid_err_overlap: got=%0d required=0", n_both);
        end
    endtask

    task automatic test_timeout();
        int e0 = n_err;
        int lo;
        int hi;
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        // Drive-to-strobe latency is 2 sync + FILTER_LEN samples, then TMO counted cycles.
        lo = last_low_cyc + TMO + 5;
        hi = last_low_cyc + TMO + 9;
        for (int i = 0; i < 3000 && n_err == e0; i++) @(negedge clk);
        @(negedge clk);
        total++;
        if (n_err - e0 !== 1) begin
            bad++;
            $display("FAIL timeout_err_pulse: got=%0d required=1", n_err - e0);
        end
        total++;
        if (err_cyc < lo || err_cyc > hi) begin
            bad++;
            $display("FAIL timeout_latency: got=%0d required=%0d..%0d", err_cyc, lo, hi);
        end
        repeat (20) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1);
        total++;
        if ({scancode, keypressed, extended} !== {8'h5A, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL timeout_recover: got=%h/%b/%b required=5a/1/0", scancode, keypressed, extended);
        end
    endtask

    task automatic test_glitch_reset();
        int v0;
        int e0;
        @(negedge clk) ps2_data = 1'b0;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h6B, 1'b0, 1'b1);
        total++;
        if (n_valid - v0 !== 1 || n_err - e0 !== 0 || last_data !== 8'h6B) begin
            bad++;
            $display("FAIL glitch_frame: got valid=%0d err=%0d data=%h required 1/0/6b",
                     n_valid - v0, n_err - e0, last_data);
        end
        total++;
        if ({scancode, keypressed, extended} !== {8'h6B, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL glitch_decode: got=%h/%b/%b required=6b/1/0", scancode, keypressed, extended);
        end
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({scancode, keypressed, extended, rx_data, rx_valid, rx_err} !== 20'h0) begin
            bad++;
            $display("FAIL midframe_reset: got=%h required=0",
                     {scancode, keypressed, extended, rx_data, rx_valid, rx_err});
        end
        repeat (20) @(negedge clk);
        v0 = n_valid;
        send_frame(8'h6B, 1'b0, 1'b1);
        total++;
        if ({scancode, keypressed, extended} !== {8'h6B, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL post_reset_decode: got=%h/%b/%b required=6b/1/0", scancode, keypressed, extended);
        end
        total++;
        if (n_valid - v0 !== 1 || last_data !== 8'h6B) begin
            bad++;
            $display("FAIL post_reset_rx: got valid=%0d data=%h required 1/6b", n_valid - v0, last_data);
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_break_repeat();
        test_extended();
        test_bad_frames();
        test_timeout();
        test_glitch_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
